// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl: sequencer for a bit-serial magnitude comparator.
// One N-bit operand pair per accepted start, scanned MSB-first at one bit per
// clock, with an early exit on the first differing bit. The result flags and
// the examined-bit count are held until the next accepted start.
//
// Build option: define SERIAL_CMP_GRAY_IN_EN to treat a/b as Gray-coded. Each
// operand is then decoded to binary in the load path, with no added latency.
// Port list and timing are the same in both builds.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while ready=1
//   a, b   in   N-bit operands, sampled on an accepted start
//   ready  out  a start will be accepted (IDLE or DONE)
//   busy   out  comparison in progress
//   done   out  one-cycle pulse; result flags are valid from this cycle
//   aeqb   out  A == B
//   agtb   out  A > B (unsigned)
//   altb   out  A < B (unsigned)
//   cycles out  number of bits examined for the last result (1..N)
module serial_cmp_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          aeqb,
  output logic          agtb,
  output logic          altb,
  output logic [IW:0]   cycles
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]    state, state_nx;
  logic [N-1:0]  ra, rb, ra_nx, rb_nx;
  logic [N-1:0]  lda, ldb;
  logic [N-1:0]  sha, shb;
  logic [IW-1:0] idx, idx_nx;
  logic          bit_a, bit_b;
  logic          aeqb_nx, agtb_nx, altb_nx;
  logic [IW:0]   cycles_nx;
  logic          ready_nx, busy_nx, done_nx;

`ifdef SERIAL_CMP_GRAY_IN_EN
  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] r;
    r = g;
    for (int unsigned s = 1; s < N; s++) begin
      r = r ^ (g >> s);
    end
    return r;
  endfunction

  assign lda = gray2bin(a);
  assign ldb = gray2bin(b);
`else
  assign lda = a;
  assign ldb = b;
`endif

  // Current bit under examination; shifting avoids an index narrower/wider than N.
  assign sha   = ra >> idx;
  assign shb   = rb >> idx;
  assign bit_a = sha[0];
  assign bit_b = shb[0];

  // Next-state and next-output logic.
  always_comb begin
    state_nx  = state;
    ra_nx     = ra;
    rb_nx     = rb;
    idx_nx    = idx;
    aeqb_nx   = aeqb;
    agtb_nx   = agtb;
    altb_nx   = altb;
    cycles_nx = cycles;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx  = COMPARE;
          ra_nx     = lda;
          rb_nx     = ldb;
          idx_nx    = IW'(N - 1);
          aeqb_nx   = 1'b0;
          agtb_nx   = 1'b0;
          altb_nx   = 1'b0;
          cycles_nx = '0;
        end else if (state == DONE) begin
          state_nx = IDLE;
        end
      end
      COMPARE: begin
        cycles_nx = cycles + (IW+1)'(1);
        if (bit_a && !bit_b) begin
          agtb_nx  = 1'b1;
          state_nx = DONE;
        end else if (!bit_a && bit_b) begin
          altb_nx  = 1'b1;
          state_nx = DONE;
        end else if (idx == '0) begin
          aeqb_nx  = 1'b1;
          state_nx = DONE;
        end else begin
          idx_nx = idx - IW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    ready_nx = (state_nx != COMPARE);
    busy_nx  = (state_nx == COMPARE);
    done_nx  = (state_nx == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      idx    <= '0;
      aeqb   <= 1'b0;
      agtb   <= 1'b0;
      altb   <= 1'b0;
      cycles <= '0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      ra     <= ra_nx;
      rb     <= rb_nx;
      idx    <= idx_nx;
      aeqb   <= aeqb_nx;
      agtb   <= agtb_nx;
      altb   <= altb_nx;
      cycles <= cycles_nx;
      ready  <= ready_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl (N=8). Stimulus pushes the expected
// flags, bit count and start-to-done latency; a negedge monitor pops and
// compares whenever done is seen.
module tb_serial_cmp_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  a, b;
  logic          ready, busy, done, aeqb, agtb, altb;
  logic [IW:0]   cycles;

  typedef struct {
    logic [2:0] flags;   // {aeqb, agtb, altb}
    int         cyc;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  serial_cmp_ctrl #(.N(N), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done),
    .aeqb(aeqb), .agtb(agtb), .altb(altb), .cycles(cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"},  int'(ready),  1);
    check({tag, " busy"},   int'(busy),   0);
    check({tag, " done"},   int'(done),   0);
    check({tag, " flags"},  int'({aeqb, agtb, altb}), 0);
    check({tag, " cycles"}, int'(cycles), 0);
  endtask

  // Wait (bounded) for ready, then present one request for exactly one edge.
  task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic push,
                       input logic [2:0] fl, input int cy, input int lat);
    int w;
    exp_t e;
    w = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", int'(ready), 1);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.flags = fl; e.cyc = cy; e.lat = lat; e.acc = cyc_cnt;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: result on done; all flags must be clear while comparing.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("flags",   int'({aeqb, agtb, altb}), int'(e.flags));
          check("cycles",  int'(cycles), e.cyc);
          check("latency", cyc_cnt - e.acc, e.lat);
          check("ready_in_done", int'(ready), 1);
        end
      end
      if (busy) begin
        check("flags_clear_busy", int'({aeqb, agtb, altb}), 0);
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_reset_outputs("reset");
    @(negedge clk);

`ifdef SERIAL_CMP_GRAY_IN_EN
    issue(8'hC0, 8'h40, 1'b1, 3'b010, 1, 1);
    issue(8'h01, 8'h03, 1'b1, 3'b001, 7, 7);
    issue(8'hA5, 8'hA5, 1'b1, 3'b100, 8, 8);
`else
    issue(8'h80, 8'h7F, 1'b1, 3'b010, 1, 1);
    issue(8'h00, 8'h01, 1'b1, 3'b001, 8, 8);
    issue(8'hA5, 8'hA5, 1'b1, 3'b100, 8, 8);
    // Back-to-back: issued in the DONE cycle of the previous request.
    issue(8'h10, 8'h20, 1'b1, 3'b001, 3, 3);

    // Start pulse and operand change mid-compare must be ignored.
    issue(8'h00, 8'h01, 1'b1, 3'b001, 8, 8);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b0;

    // Abort a request with reset: no done, reset values, then a fresh start.
    issue(8'h00, 8'h01, 1'b0, 3'b000, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    issue(8'h03, 8'h03, 1'b1, 3'b100, 8, 8);
    issue(8'h3C, 8'h3D, 1'b1, 3'b001, 8, 8);
    issue(8'hFE, 8'hEF, 1'b1, 3'b010, 4, 4);
`endif

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("final_busy", int'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
